// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480@60 VGA raster timing, blanked colour and sync outputs
// Optional colour-bar source enabled by defining VGA_TIMING_TESTPATTERN_EN.
module vga_timing #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        en,
`ifdef VGA_TIMING_TESTPATTERN_EN
    input  logic        pattern_en,
`endif
    input  logic [11:0] px_color,
    output logic        pix_ce,
    output logic [9:0]  hpos,
    output logic [9:0]  vpos,
    output logic        active,
    output logic        line_start,
    output logic        frame_start,
    output logic [11:0] vga_color,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_SYNC == 0 || V_SYNC == 0 || CLK_DIV == 0) begin : g_cfg_err
        $error("vga_timing: unsupported timing parameters");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       hpos_q, hpos_d;
    logic [9:0]       vpos_q, vpos_d;
    logic [11:0]      color_q;
    logic             hs_q, vs_q;
    logic             pix_ce_w, active_w, h_wrap, v_wrap, hs_on, vs_on;
    logic [11:0]      src_color;

    assign pix_ce_w = en && (div_q == DIV_LAST);
    assign active_w = (hpos_q < H_ACT) && (vpos_q < V_ACT);
    assign h_wrap   = (hpos_q == H_LAST);
    assign v_wrap   = (vpos_q == V_LAST);
    assign hs_on    = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
    assign vs_on    = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);

    always_comb begin
        div_d  = div_q;
        hpos_d = hpos_q;
        vpos_d = vpos_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
        if (pix_ce_w) begin
            if (h_wrap) begin
                hpos_d = '0;
                vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
            end else begin
                hpos_d = hpos_q + 1'b1;
            end
        end
    end

`ifdef VGA_TIMING_TESTPATTERN_EN
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

    if (H_ACTIVE % 8 != 0) begin : g_bar_err
        $error("vga_timing: H_ACTIVE must be a multiple of 8 for the test pattern");
    end

    logic [BAR_CW-1:0] bar_px_q, bar_px_d;
    logic [2:0]        bar_q, bar_d;

    // Bar index tracks hpos/BAR_W incrementally so no divider is needed.
    always_comb begin
        bar_px_d = bar_px_q;
        bar_d    = bar_q;
        if (pix_ce_w) begin
            if (h_wrap) begin
                bar_px_d = '0;
                bar_d    = '0;
            end else if (hpos_q < H_ACT) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d = '0;
                    bar_d    = bar_q + 1'b1;
                end else begin
                    bar_px_d = bar_px_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            bar_px_q <= '0;
            bar_q    <= '0;
        end else begin
            bar_px_q <= bar_px_d;
            bar_q    <= bar_d;
        end
    end

    assign src_color = pattern_en ? {{4{bar_q[2]}}, {4{bar_q[1]}}, {4{bar_q[0]}}} : px_color;
`else
    assign src_color = px_color;
`endif

    // Output stage samples the pre-increment position, so it lags hpos/vpos by one pixel.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            div_q   <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            color_q <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
        end else begin
            div_q  <= div_d;
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            if (pix_ce_w) begin
                color_q <= active_w ? src_color : 12'h000;
                hs_q    <= hs_on ? SYNC_POL : ~SYNC_POL;
                vs_q    <= vs_on ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign pix_ce      = pix_ce_w;
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign active      = active_w;
    assign line_start  = pix_ce_w && h_wrap;
    assign frame_start = pix_ce_w && h_wrap && v_wrap;
    assign vga_color   = color_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - randomized scoreboard bench for vga_timing (small raster plus default raster)
module tb_vga_timing;

    localparam int CD  = 2;
    localparam int HA  = 64;
    localparam int HFP = 8;
    localparam int HS  = 12;
    localparam int HBP = 0;
    localparam int VA  = 20;
    localparam int VFP = 0;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst_n = 1'b0, a_en = 1'b0, a_pattern = 1'b0;
    logic [11:0] a_px = 12'h000;
    logic        a_pix_ce, a_active, a_ls, a_fs, a_hs, a_vs;
    logic [9:0]  a_hpos, a_vpos;
    logic [11:0] a_col;

    logic        b_rst_n = 1'b0, b_en = 1'b0;
    logic [11:0] b_px = 12'hFFF;
    logic        b_pix_ce, b_active, b_ls, b_fs, b_hs, b_vs;
    logic [9:0]  b_hpos, b_vpos;
    logic [11:0] b_col;

    vga_timing #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_POL(1'b0)
    ) u_dut_a (
        .clk(clk), .rst_(a_rst_n), .en(a_en),
`ifdef VGA_TIMING_TESTPATTERN_EN
        .pattern_en(a_pattern),
`endif
        .px_color(a_px), .pix_ce(a_pix_ce), .hpos(a_hpos), .vpos(a_vpos),
        .active(a_active), .line_start(a_ls), .frame_start(a_fs),
        .vga_color(a_col), .vga_hs(a_hs), .vga_vs(a_vs)
    );

    vga_timing u_dut_b (
        .clk(clk), .rst_(b_rst_n), .en(b_en),
`ifdef VGA_TIMING_TESTPATTERN_EN
        .pattern_en(1'b0),
`endif
        .px_color(b_px), .pix_ce(b_pix_ce), .hpos(b_hpos), .vpos(b_vpos),
        .active(b_active), .line_start(b_ls), .frame_start(b_fs),
        .vga_color(b_col), .vga_hs(b_hs), .vga_vs(b_vs)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          h;
        int          v;
        bit          act;
        bit          ls;
        bit          fs;
        logic [11:0] col;
        bit          hs;
        bit          vs;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned e_cnt = 0;
    logic [11:0] m_col = 12'h000;
    bit          m_hs = 1'b1, m_vs = 1'b1;
    int          exp_frames = 0, got_frames = 0;

    function automatic logic [11:0] bar_color(input int h);
        logic [2:0] k;
        k = 3'(h / (HA / 8));
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction

    function automatic bit in_sync(input int p, input int first, input int width);
        return (p >= first) && (p < first + width);
    endfunction

    // One clock of stimulus; the pixel finishing on the next edge (if any) is predicted from
    // the count of enabled clocks since reset, independent of any DUT state.
    task automatic drive(input bit en_v);
        exp_t r;
        int   n;
        @(negedge clk);
        a_en = en_v;
        a_px = 12'($urandom);
        if (en_v && (e_cnt % CD == CD - 1)) begin
            n     = int'(e_cnt / CD);
            r.h   = n % HT;
            r.v   = (n / HT) % VT;
            r.act = (r.h < HA) && (r.v < VA);
            r.ls  = (r.h == HT - 1);
            r.fs  = (r.h == HT - 1) && (r.v == VT - 1);
            r.col = m_col;
            r.hs  = m_hs;
            r.vs  = m_vs;
            sb_q.push_back(r);
            if (r.fs) exp_frames++;
            m_col = r.act ? (a_pattern ? bar_color(r.h) : a_px) : 12'h000;
            m_hs  = !in_sync(r.h, HA + HFP, HS);
            m_vs  = !in_sync(r.v, VA + VFP, VS);
        end
        if (en_v) e_cnt++;
    endtask

    task automatic model_reset();
        e_cnt = 0;
        m_col = 12'h000;
        m_hs  = 1'b1;
        m_vs  = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t r;
        #1;
        if (a_rst_n) begin
            if (!a_en) check("a_pix_ce_while_disabled", a_pix_ce, 0);
            if (a_pix_ce) begin
                if (sb_q.size() == 0) begin
                    check("a_unexpected_pix_ce", 1, 0);
                end else begin
                    r = sb_q.pop_front();
                    check("a_hpos", a_hpos, r.h);
                    check("a_vpos", a_vpos, r.v);
                    check("a_active", a_active, r.act);
                    check("a_line_start", a_ls, r.ls);
                    check("a_frame_start", a_fs, r.fs);
                    check("a_vga_color", a_col, r.col);
                    check("a_vga_hs", a_hs, r.hs);
                    check("a_vga_vs", a_vs, r.vs);
                    if (a_fs) got_frames++;
                end
            end else begin
                if (a_ls) check("a_line_start_without_pix_ce", a_ls, 0);
                if (sb_q.size() != 0) begin
                    check("a_missing_pix_ce", 0, 1);
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    int   b_cyc = 0, b_last_ls = -1, b_last_h = -1, b_hs_low = 0, b_lines = 0;
    logic b_prev_hs = 1'b1;
    logic [11:0] b_prev_col = 12'h000;

    always @(negedge clk) begin
        #1;
        if (b_rst_n) begin
            b_cyc++;
            if (b_ls) begin
                if (b_last_ls >= 0) check("b_line_period", b_cyc - b_last_ls, 1600);
                b_last_ls = b_cyc;
                b_lines++;
            end
            if (b_prev_hs && !b_hs) begin
                check("b_hs_assert_after_hpos", b_last_h, 656);
                b_hs_low = 0;
            end
            if (!b_hs) b_hs_low++;
            if (!b_prev_hs && b_hs) check("b_hs_low_clocks", b_hs_low, 192);
            if (b_prev_col == 12'hFFF && b_col == 12'h000) check("b_blank_after_hpos", b_last_h, 640);
            if (b_prev_col == 12'h000 && b_col == 12'hFFF) check("b_unblank_after_hpos", b_last_h, 0);
            if (b_pix_ce) b_last_h = b_hpos;
            b_prev_hs  = b_hs;
            b_prev_col = b_col;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_hpos"}, a_hpos, 0);
        check({tag, "_vpos"}, a_vpos, 0);
        check({tag, "_vga_color"}, a_col, 0);
        check({tag, "_vga_hs"}, a_hs, 1);
        check({tag, "_vga_vs"}, a_vs, 1);
        check({tag, "_pix_ce"}, a_pix_ce, 0);
        check({tag, "_line_start"}, a_ls, 0);
        check({tag, "_frame_start"}, a_fs, 0);
        check({tag, "_active"}, a_active, 1);
    endtask

    initial begin
        bit gap_done;
        int guard;
        gap_done = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("rst_init");
        @(negedge clk);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        b_en    = 1'b1;
        model_reset();

        for (int c = 0; c < 11000; c++) begin
`ifdef VGA_TIMING_TESTPATTERN_EN
            if (c == 6000) a_pattern = 1'b1;
            if (c == 8500) a_pattern = 1'b0;
`endif
            if (!gap_done && e_cnt % CD == 0 && e_cnt / CD == 3 * HT + 40) begin
                repeat (37) drive(1'b0);
                gap_done = 1'b1;
            end
            drive($urandom_range(0, 15) != 0);
        end

        guard = 0;
        while (!(((e_cnt - 1) / CD) % (HT * VT) == 12 * HT + 30) && guard < 20000) begin
            drive(1'b1);
            guard++;
        end
        check("reach_reset_point", guard < 20000, 1);
        #3;
        a_rst_n = 1'b0;
        a_en    = 1'b0;
        #1;
        check_reset_values("rst_async");
        check("sb_empty_at_reset", sb_q.size(), 0);
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        a_rst_n = 1'b1;

        for (int c = 0; c < HT * VT * CD + 300; c++) drive(1'b1);
        repeat (4) drive(1'b0);

        check("a_frames_seen", got_frames, exp_frames);
        check("a_frames_min", exp_frames >= 3, 1);
        check("sb_drained", sb_q.size(), 0);
        check("b_lines_seen", b_lines >= 8, 1);
        check("b_vga_vs_idle", b_vs, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
